pcie_frame_checker: RTL and testbench

Receive-side framing checker for the PCIe physical-layer byte path. It sits directly downstream of the symbol multiplexer, which places one byte per `CLK_2MHz` cycle on its output from the TLP/COM/PAD/SKP/STP/SDP/END/EDB/FTS/IDL sources. It parses that stream into TLP frames, DLLP frames and ordered sets. It forwards payload bytes with start/end markers and keeps good-TLP and error counters.

---
 rtl/pcie_frame_checker.sv | 190 +++++++++++++++++++
 tb/tb_pcie_frame_checker.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_frame_checker.sv
// Receive-side PCIe framing checker: parses the symbol stream into TLP/DLLP frames and ordered sets.
// Optional feature macro FRAME_DLLP_LEN_CHECK_EN: a DLLP must carry exactly 6 payload bytes.
module pcie_frame_checker #(
    parameter logic [7:0]  SYM_COM = 8'hF2,
    parameter logic [7:0]  SYM_PAD = 8'hC7,
    parameter logic [7:0]  SYM_SKP = 8'hAC,
    parameter logic [7:0]  SYM_STP = 8'hAA,
    parameter logic [7:0]  SYM_SDP = 8'hE5,
    parameter logic [7:0]  SYM_END = 8'hF6,
    parameter logic [7:0]  SYM_EDB = 8'hDF,
    parameter logic [7:0]  SYM_FTS = 8'hA8,
    parameter logic [7:0]  SYM_IDL = 8'hAE,
    parameter int unsigned MAX_TLP = 32
) (
    input  logic       CLK_2MHz,
    input  logic       reset,
    input  logic       ENB,
    input  logic [7:0] IN_BYTE,
    input  logic       IN_K,
    output logic [7:0] OUT_DATA,
    output logic       OUT_DATA_VALID,
    output logic       OUT_SOP,
    output logic       OUT_EOP,
    output logic       OUT_ABORT,
    output logic       OUT_IS_DLLP,
    output logic       OUT_OS_VALID,
    output logic [1:0] OUT_OS_TYPE,
    output logic [7:0] TLP_CNT,
    output logic [7:0] ERR_CNT
);
    typedef enum logic [1:0] {ST_IDLE, ST_TLP, ST_DLLP, ST_OS} state_t;

    localparam logic [7:0] TLP_LIM = 8'(MAX_TLP);
`ifdef FRAME_DLLP_LEN_CHECK_EN
    localparam logic [7:0] DLLP_LIM = 8'd6;
`else
    localparam logic [7:0] DLLP_LIM = TLP_LIM;
`endif

    state_t     state_q;
    logic [7:0] len_q;
    logic [1:0] os_idx_q;
    logic [7:0] os_sym_q;
    logic [7:0] data_q;
    logic       vld_q;
    logic       sop_q;
    logic       eop_q;
    logic       abort_q;
    logic       dllp_q;
    logic       osv_q;
    logic [1:0] os_type_q;
    logic [7:0] tlp_cnt_q;
    logic [7:0] err_cnt_q;

    logic       is_start;
    logic       is_os_sym;
    logic       in_frame;
    logic       len_ok;
    logic [7:0] lim;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [1:0] os_code(input logic [7:0] sym);
        if (sym == SYM_SKP) return 2'd0;
        if (sym == SYM_FTS) return 2'd1;
        return 2'd2;
    endfunction

    // STP/SDP/COM always open a new frame or ordered set, whatever was in progress
    always_comb begin
        is_start  = IN_K && (IN_BYTE == SYM_STP || IN_BYTE == SYM_SDP || IN_BYTE == SYM_COM);
        is_os_sym = IN_K && (IN_BYTE == SYM_SKP || IN_BYTE == SYM_FTS || IN_BYTE == SYM_IDL);
        in_frame  = (state_q == ST_TLP) || (state_q == ST_DLLP);
        lim       = (state_q == ST_DLLP) ? DLLP_LIM : TLP_LIM;
`ifdef FRAME_DLLP_LEN_CHECK_EN
        len_ok    = (state_q == ST_DLLP) ? (len_q == 8'd6) : (len_q != 8'd0);
`else
        len_ok    = (len_q != 8'd0);
`endif
    end

    always_ff @(posedge CLK_2MHz) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            len_q     <= 8'd0;
            os_idx_q  <= 2'd0;
            os_sym_q  <= 8'd0;
            data_q    <= 8'd0;
            vld_q     <= 1'b0;
            sop_q     <= 1'b0;
            eop_q     <= 1'b0;
            abort_q   <= 1'b0;
            dllp_q    <= 1'b0;
            osv_q     <= 1'b0;
            os_type_q <= 2'd0;
            tlp_cnt_q <= 8'd0;
            err_cnt_q <= 8'd0;
        end else begin
            vld_q   <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            abort_q <= 1'b0;
            osv_q   <= 1'b0;
            if (ENB) begin
                if (is_start) begin
                    len_q    <= 8'd0;
                    os_idx_q <= 2'd0;
                    if (state_q != ST_IDLE) err_cnt_q <= sat_inc(err_cnt_q);
                    if (in_frame) abort_q <= 1'b1;
                    if (IN_BYTE == SYM_STP) begin
                        state_q <= ST_TLP;
                        dllp_q  <= 1'b0;
                    end else if (IN_BYTE == SYM_SDP) begin
                        state_q <= ST_DLLP;
                        dllp_q  <= 1'b1;
                    end else begin
                        state_q <= ST_OS;
                    end
                end else begin
                    case (state_q)
                        ST_IDLE: begin
                            if (!(IN_K && IN_BYTE == SYM_PAD)) err_cnt_q <= sat_inc(err_cnt_q);
                        end
                        ST_TLP, ST_DLLP: begin
                            if (!IN_K) begin
                                if (len_q >= lim) begin
                                    err_cnt_q <= sat_inc(err_cnt_q);
                                    abort_q   <= 1'b1;
                                    state_q   <= ST_IDLE;
                                end else begin
                                    data_q <= IN_BYTE;
                                    vld_q  <= 1'b1;
                                    sop_q  <= (len_q == 8'd0);
                                    len_q  <= len_q + 8'd1;
                                end
                            end else if (IN_BYTE == SYM_END) begin
                                if (len_ok) begin
                                    eop_q <= 1'b1;
                                    if (state_q == ST_TLP) tlp_cnt_q <= tlp_cnt_q + 8'd1;
                                end else begin
                                    err_cnt_q <= sat_inc(err_cnt_q);
                                    abort_q   <= 1'b1;
                                end
                                state_q <= ST_IDLE;
                            end else begin
                                if (IN_BYTE != SYM_EDB) err_cnt_q <= sat_inc(err_cnt_q);
                                abort_q <= 1'b1;
                                state_q <= ST_IDLE;
                            end
                        end
                        // First symbol after COM picks the type; the next two must repeat it
                        ST_OS: begin
                            if (is_os_sym && (os_idx_q == 2'd0 || IN_BYTE == os_sym_q)) begin
                                if (os_idx_q == 2'd0) begin
                                    os_sym_q <= IN_BYTE;
                                    os_idx_q <= 2'd1;
                                end else if (os_idx_q == 2'd1) begin
                                    os_idx_q <= 2'd2;
                                end else begin
                                    osv_q     <= 1'b1;
                                    os_type_q <= os_code(IN_BYTE);
                                    os_idx_q  <= 2'd0;
                                    state_q   <= ST_IDLE;
                                end
                            end else begin
                                err_cnt_q <= sat_inc(err_cnt_q);
                                os_idx_q  <= 2'd0;
                                state_q   <= ST_IDLE;
                            end
                        end
                        default: state_q <= ST_IDLE;
                    endcase
                end
            end
        end
    end

    assign OUT_DATA       = data_q;
    assign OUT_DATA_VALID = vld_q;
    assign OUT_SOP        = sop_q;
    assign OUT_EOP        = eop_q;
    assign OUT_ABORT      = abort_q;
    assign OUT_IS_DLLP    = dllp_q;
    assign OUT_OS_VALID   = osv_q;
    assign OUT_OS_TYPE    = os_type_q;
    assign TLP_CNT        = tlp_cnt_q;
    assign ERR_CNT        = err_cnt_q;
endmodule

// File: tb/tb_pcie_frame_checker.sv
// Self-checking bench for pcie_frame_checker: directed sequences plus randomized traffic
// against a queue-based behavioural model of the framing rules.
module tb_pcie_frame_checker;
    localparam logic [7:0] COM  = 8'hF2;
    localparam logic [7:0] PAD  = 8'hC7;
    localparam logic [7:0] SKP  = 8'hAC;
    localparam logic [7:0] STP  = 8'hAA;
    localparam logic [7:0] SDP  = 8'hE5;
    localparam logic [7:0] ENDS = 8'hF6;
    localparam logic [7:0] EDB  = 8'hDF;
    localparam logic [7:0] FTS  = 8'hA8;
    localparam logic [7:0] IDL  = 8'hAE;
    localparam int         MAXT = 32;
`ifdef FRAME_DLLP_LEN_CHECK_EN
    localparam bit DLLP_CHK = 1'b1;
`else
    localparam bit DLLP_CHK = 1'b0;
`endif

    logic       CLK_2MHz = 1'b0;
    logic       reset = 1'b1;
    logic       ENB = 1'b0;
    logic [7:0] IN_BYTE = 8'h00;
    logic       IN_K = 1'b0;
    logic [7:0] OUT_DATA;
    logic       OUT_DATA_VALID, OUT_SOP, OUT_EOP, OUT_ABORT, OUT_IS_DLLP, OUT_OS_VALID;
    logic [1:0] OUT_OS_TYPE;
    logic [7:0] TLP_CNT, ERR_CNT;

    pcie_frame_checker dut (
        .CLK_2MHz(CLK_2MHz), .reset(reset), .ENB(ENB), .IN_BYTE(IN_BYTE), .IN_K(IN_K),
        .OUT_DATA(OUT_DATA), .OUT_DATA_VALID(OUT_DATA_VALID), .OUT_SOP(OUT_SOP),
        .OUT_EOP(OUT_EOP), .OUT_ABORT(OUT_ABORT), .OUT_IS_DLLP(OUT_IS_DLLP),
        .OUT_OS_VALID(OUT_OS_VALID), .OUT_OS_TYPE(OUT_OS_TYPE),
        .TLP_CNT(TLP_CNT), .ERR_CNT(ERR_CNT)
    );

    always #5 CLK_2MHz = ~CLK_2MHz;

    int n_chk = 0;
    int n_err = 0;
    int n_vld = 0, n_eop = 0, n_abort = 0, n_osv = 0;
    bit chk_en = 1'b0;

    // Model: context 0 = none, 1 = TLP, 2 = DLLP, 3 = ordered set; payload and OS symbols kept in queues
    int         ctx = 0;
    logic [7:0] pay_q[$];
    logic [7:0] os_q[$];
    logic [7:0] e_data = 8'h00, e_tlp = 8'h00, e_err = 8'h00;
    logic       e_vld = 0, e_sop = 0, e_eop = 0, e_abort = 0, e_dllp = 0, e_osv = 0;
    logic [1:0] e_ostype = 2'd0;
    logic [7:0] kset [9] = '{COM, PAD, SKP, STP, SDP, ENDS, EDB, FTS, IDL};

    task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at t=%0t: got %0h want %0h", nm, $time, act, exp);
        end
    endtask

    task automatic bump_err();
        if (e_err != 8'hFF) e_err = e_err + 8'd1;
    endtask

    task automatic model_step(input bit rst, input bit en, input bit k, input logic [7:0] b);
        int  limit;
        bit  good;
        e_vld = 0; e_sop = 0; e_eop = 0; e_abort = 0; e_osv = 0;
        if (rst) begin
            e_data = 8'h00; e_ostype = 2'd0; e_dllp = 0; e_tlp = 8'h00; e_err = 8'h00;
            ctx = 0; pay_q.delete(); os_q.delete();
        end else if (en) begin
            if (k && (b == STP || b == SDP || b == COM)) begin
                if (ctx != 0) bump_err();
                if (ctx == 1 || ctx == 2) e_abort = 1;
                pay_q.delete(); os_q.delete();
                ctx = (b == STP) ? 1 : (b == SDP) ? 2 : 3;
                if (b == STP) e_dllp = 0;
                else if (b == SDP) e_dllp = 1;
            end else if (ctx == 0) begin
                if (!(k && b == PAD)) bump_err();
            end else if (ctx == 3) begin
                if (k && (b == SKP || b == FTS || b == IDL) && (os_q.size() == 0 || b == os_q[0])) begin
                    os_q.push_back(b);
                    if (os_q.size() == 3) begin
                        e_osv = 1;
                        e_ostype = (b == SKP) ? 2'd0 : (b == FTS) ? 2'd1 : 2'd2;
                        ctx = 0;
                    end
                end else begin
                    bump_err(); ctx = 0;
                end
            end else begin
                limit = (ctx == 2 && DLLP_CHK) ? 6 : MAXT;
                if (!k) begin
                    if (pay_q.size() >= limit) begin
                        bump_err(); e_abort = 1; ctx = 0;
                    end else begin
                        e_sop = (pay_q.size() == 0);
                        pay_q.push_back(b);
                        e_vld = 1; e_data = b;
                    end
                end else if (b == ENDS) begin
                    good = (ctx == 2 && DLLP_CHK) ? (pay_q.size() == 6) : (pay_q.size() >= 1);
                    if (good) begin
                        e_eop = 1;
                        if (ctx == 1) e_tlp = e_tlp + 8'd1;
                    end else begin
                        bump_err(); e_abort = 1;
                    end
                    ctx = 0;
                end else begin
                    if (b != EDB) bump_err();
                    e_abort = 1; ctx = 0;
                end
            end
        end
    endtask

    always @(posedge CLK_2MHz) begin
        #1;
        if (chk_en) begin
            cmp("OUT_DATA", OUT_DATA, e_data);
            cmp("OUT_DATA_VALID", {7'd0, OUT_DATA_VALID}, {7'd0, e_vld});
            cmp("OUT_SOP", {7'd0, OUT_SOP}, {7'd0, e_sop});
            cmp("OUT_EOP", {7'd0, OUT_EOP}, {7'd0, e_eop});
            cmp("OUT_ABORT", {7'd0, OUT_ABORT}, {7'd0, e_abort});
            cmp("OUT_IS_DLLP", {7'd0, OUT_IS_DLLP}, {7'd0, e_dllp});
            cmp("OUT_OS_VALID", {7'd0, OUT_OS_VALID}, {7'd0, e_osv});
            cmp("OUT_OS_TYPE", {6'd0, OUT_OS_TYPE}, {6'd0, e_ostype});
            cmp("TLP_CNT", TLP_CNT, e_tlp);
            cmp("ERR_CNT", ERR_CNT, e_err);
            n_vld   += int'(OUT_DATA_VALID);
            n_eop   += int'(OUT_EOP);
            n_abort += int'(OUT_ABORT);
            n_osv   += int'(OUT_OS_VALID);
        end
    end

    task automatic send(input bit rst, input bit en, input bit k, input logic [7:0] b);
        @(negedge CLK_2MHz);
        reset = rst; ENB = en; IN_K = k; IN_BYTE = b;
        model_step(rst, en, k, b);
        chk_en = 1'b1;
    endtask

    task automatic sk(input logic [7:0] b);
        send(0, 1, 1, b);
    endtask

    task automatic sd(input logic [7:0] b);
        send(0, 1, 0, b);
    endtask

    task automatic settle();
        @(posedge CLK_2MHz);
        #2;
    endtask

    task automatic lit(input string nm, input int act, input int exp);
        cmp(nm, 8'(act), 8'(exp));
    endtask

    task automatic rsend(input bit k, input logic [7:0] b);
        if ($urandom_range(0, 9) == 0) send(0, 0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
        if ($urandom_range(0, 199) == 0) send(1, 1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
        send(0, 1, k, b);
    endtask

    initial begin
        int s_vld, s_eop, s_abort, s_osv;
        logic [7:0] sym;

        // Reset and idle padding
        send(1, 1, 0, 8'h55);
        send(1, 0, 1, STP);
        settle();
        lit("rst_err", ERR_CNT, 0);
        lit("rst_tlp", TLP_CNT, 0);
        lit("rst_data", OUT_DATA, 0);
        lit("rst_dllp", OUT_IS_DLLP, 0);
        repeat (4) sk(PAD);
        settle();
        lit("pad_err", ERR_CNT, 0);

        // Good TLP
        s_vld = n_vld; s_eop = n_eop;
        sk(STP); sd(8'hFF); sd(8'hFF); sd(8'hFF); sk(ENDS);
        settle();
        lit("tlp_vld_cnt", n_vld - s_vld, 3);
        lit("tlp_eop_cnt", n_eop - s_eop, 1);
        lit("tlp_cnt", TLP_CNT, 1);
        lit("tlp_err", ERR_CNT, 0);
        lit("tlp_data", OUT_DATA, 8'hFF);

        // Ordered sets
        s_osv = n_osv;
        sk(COM); sk(SKP); sk(SKP); sk(SKP);
        sk(COM); sk(FTS); sk(FTS); sk(FTS);
        sk(COM); sk(IDL); sk(IDL); sk(IDL);
        settle();
        lit("os_cnt", n_osv - s_osv, 3);
        lit("os_last_type", OUT_OS_TYPE, 2);
        sk(COM); sk(SKP); sk(FTS);
        settle();
        lit("os_bad_err", ERR_CNT, 1);
        lit("os_bad_cnt", n_osv - s_osv, 3);

        // EDB abort, then SDP interrupting a TLP
        s_abort = n_abort;
        sk(STP); sd(8'hFF); sk(EDB);
        settle();
        lit("edb_abort", n_abort - s_abort, 1);
        lit("edb_tlp", TLP_CNT, 1);
        lit("edb_err", ERR_CNT, 1);
        s_eop = n_eop;
        sk(STP); sd(8'hFF); sk(SDP);
        settle();
        lit("sdp_abort", n_abort - s_abort, 2);
        lit("sdp_err", ERR_CNT, 2);
        repeat (6) sd(8'hFF);
        sk(ENDS);
        settle();
        lit("dllp_flag", OUT_IS_DLLP, 1);
        lit("dllp_eop", n_eop - s_eop, 1);
        lit("dllp_tlp", TLP_CNT, 1);

        // Short DLLP
        sk(SDP); repeat (4) sd(8'hFF); sk(ENDS);
        settle();
        lit("dllp4_err", ERR_CNT, DLLP_CHK ? 3 : 2);

        // ENB low mid-TLP
        sk(STP); sd(8'h12);
        repeat (3) send(0, 0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
        sd(8'h34); sk(ENDS);
        settle();
        lit("enb_tlp", TLP_CNT, 2);
        lit("enb_data", OUT_DATA, 8'h34);

        // MAX_TLP boundary: full-length good, then one byte over
        sk(STP); for (int i = 0; i < MAXT; i++) sd(8'(i)); sk(ENDS);
        settle();
        lit("max_tlp", TLP_CNT, 3);
        sk(STP); for (int i = 0; i <= MAXT; i++) sd(8'(i + 100));
        settle();
        lit("over_data", OUT_DATA, 8'(MAXT - 1 + 100));

        // Error counter saturation
        repeat (300) sd(8'h5A);
        settle();
        lit("err_sat", ERR_CNT, 255);

        // Reset mid-TLP
        s_abort = n_abort;
        sk(STP); sd(8'h01); sd(8'h02);
        send(1, 1, 0, 8'h03);
        settle();
        lit("rstmid_abort", n_abort - s_abort, 0);
        lit("rstmid_tlp", TLP_CNT, 0);
        lit("rstmid_err", ERR_CNT, 0);

        // TLP counter wrap
        repeat (255) begin sk(STP); sd(8'h77); sk(ENDS); end
        settle();
        lit("wrap_255", TLP_CNT, 255);
        sk(STP); sd(8'h77); sk(ENDS);
        settle();
        lit("wrap_0", TLP_CNT, 0);

        // Randomized traffic
        for (int it = 0; it < 200; it++) begin
            case ($urandom_range(0, 3))
                0: begin
                    rsend(1, STP);
                    repeat ($urandom_range(0, MAXT + 2)) rsend(0, 8'($urandom_range(0, 255)));
                    rsend(1, ($urandom_range(0, 4) == 0) ? EDB : ENDS);
                end
                1: begin
                    rsend(1, SDP);
                    repeat ($urandom_range(4, 7)) rsend(0, 8'($urandom_range(0, 255)));
                    rsend(1, ENDS);
                end
                2: begin
                    sym = kset[2 + 5 * ($urandom_range(0, 2) == 0) + 6 * ($urandom_range(0, 1))];
                    if (sym != SKP && sym != FTS && sym != IDL) sym = FTS;
                    rsend(1, COM);
                    for (int j = 0; j < 3; j++)
                        rsend(1, ($urandom_range(0, 9) == 0) ? kset[$urandom_range(0, 8)] : sym);
                end
                default: begin
                    repeat (4) begin
                        if ($urandom_range(0, 2) == 0) rsend(0, 8'($urandom_range(0, 255)));
                        else rsend(1, kset[$urandom_range(0, 8)]);
                    end
                end
            endcase
        end

        settle();
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
